// File: rtl/sqrt_q88.sv
// sqrt_q88: sequential square root of an unsigned Q8.8 value.
// The result is the Q8.8 square root. It is truncated by default.
// Define SQRT_ROUND_EN to round the result to nearest instead.
// The block runs a radix-2 restoring digit-by-digit algorithm on the
// 24-bit radicand {DATA_IN, 8'h00} and resolves one root bit per clock.
// The block is free-running with a 14-cycle period:
//   1 LOAD cycle, 12 ITER cycles, 1 DONE cycle.
// DATA_OUT is registered and changes only in the DONE cycle.
module sqrt_q88 (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA_IN,
  output logic [15:0] DATA_OUT
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [23:0] rad_q, rad_d;     // radicand, consumed two bits per cycle from the top
  logic [11:0] root_q, root_d;   // root built MSB first
  logic [13:0] rem_q, rem_d;     // partial remainder, never exceeds 2*root
  logic [3:0]  cnt_q, cnt_d;     // index of the root bit being resolved
  logic [15:0] out_q, out_d;

  logic [15:0] trial_s;          // remainder with the next radicand pair appended
  logic [15:0] sub_s;            // 4*root + 1
  logic [15:0] diff_s;
  logic [12:0] final_s;          // root after optional rounding, may reach 4096
  logic        unused_s;

  // Trial subtraction for the current root bit.
  always_comb begin
    trial_s = {rem_q, rad_q[23:22]};
    sub_s   = {2'b00, root_q, 2'b01};
    diff_s  = trial_s - sub_s;
  end

  // diff_s is never larger than 2*root, so its top two bits are always zero.
  assign unused_s = ^diff_s[15:14];

  // Value written to the output in DONE.
  // When rounding, remainder > root means sqrt >= root + 0.5.
  always_comb begin
`ifdef SQRT_ROUND_EN
    if (rem_q > {2'b00, root_q}) begin
      final_s = {1'b0, root_q} + 13'd1;
    end else begin
      final_s = {1'b0, root_q};
    end
`else
    final_s = {1'b0, root_q};
`endif
  end

  // Next-state and datapath control for the LOAD / ITER / DONE sequence.
  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      ST_LOAD: begin
        rad_d   = {DATA_IN, 8'h00};
        root_d  = 12'h000;
        rem_d   = 14'h0000;
        cnt_d   = 4'd11;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        rad_d = {rad_q[21:0], 2'b00};
        if (trial_s >= sub_s) begin
          rem_d  = diff_s[13:0];
          root_d = {root_q[10:0], 1'b1};
        end else begin
          // trial_s < 4*root+1 here, so it fits the remainder width.
          rem_d  = trial_s[13:0];
          root_d = {root_q[10:0], 1'b0};
        end
        if (cnt_q == 4'd0) begin
          cnt_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_ITER;
        end
      end
      ST_DONE: begin
        out_d   = {3'b000, final_s};
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State registers. Reset aborts any computation in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_LOAD;
      rad_q   <= 24'h000000;
      root_q  <= 12'h000;
      rem_q   <= 14'h0000;
      cnt_q   <= 4'd0;
      out_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign DATA_OUT = out_q;

endmodule

// File: tb/tb_sqrt_q88.sv
// Testbench for sqrt_q88.
// A table of vectors is applied, one per 14-cycle period.
// A scoreboard queues each expected value when the LOAD edge captures DATA_IN.
// The monitor pops the queue at each DONE edge and checks output hold between updates.
// Expected values follow SQRT_ROUND_EN when it is defined.
module tb_sqrt_q88;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] DATA_IN = 16'h0000;
  logic [15:0] DATA_OUT;

  always #5 CLK = ~CLK;

  sqrt_q88 dut (
    .CLK      (CLK),
    .RST      (RST),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT)
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  int          edge_n;
  logic [15:0] exp_next = 16'h0000;
  logic [15:0] load_exp;
  logic [15:0] held;
  int          total = 0;
  int          bad = 0;

  // Count edges since reset release. Latch the expectation on each LOAD edge.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_n   <= 0;
      load_exp <= 16'h0000;
    end else begin
      if (edge_n % 14 == 0) load_exp <= exp_next;
      edge_n <= edge_n + 1;
    end
  end

  function automatic logic [15:0] model_sqrt(input logic [15:0] d);
    longint n;
    longint r;
    n = longint'(d) * 256;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
`ifdef SQRT_ROUND_EN
    if (n - r * r > r) r++;
`endif
    return 16'(r);
  endfunction

  function automatic vec_t mk(input logic [15:0] d, input logic [15:0] e);
    vec_t v;
    v.din = d;
    v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Wait for the next falling edge at the given phase of the 14-cycle period.
  task automatic wait_phase(input int ph);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge CLK);
      if (edge_n % 14 == ph) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL wait_phase: phase %0d not reached, edge_n=%0d", ph, edge_n);
    end
  endtask

  initial begin
    logic [15:0] r16;

    // Scoreboard and monitor.
    fork
      forever begin
        @(negedge CLK or negedge RST);
        if (!RST) begin
          sb.delete();
          held = 16'h0000;
          #1 check("reset", DATA_OUT, 16'h0000);
        end else if (edge_n > 0) begin
          if (edge_n % 14 == 1) sb.push_back(load_exp);
          if (edge_n % 14 == 0) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("FAIL sb_empty: got no expectation want one at edge %0d", edge_n);
            end else begin
              held = sb.pop_front();
              check("done", DATA_OUT, held);
            end
          end else begin
            check("hold", DATA_OUT, held);
          end
        end
      end
      begin
        #200000;
        total++;
        bad++;
        $display("FAIL timeout: got no finish want finish before 200000");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_none

    // Vector table.
    vecs.push_back(mk(16'h0400, 16'h0200));
    vecs.push_back(mk(16'h0400, 16'h0200));
    vecs.push_back(mk(16'h1E00, 16'h057A));
    vecs.push_back(mk(16'h6400, 16'h0A00));
    vecs.push_back(mk(16'h0000, 16'h0000));
`ifdef SQRT_ROUND_EN
    vecs.push_back(mk(16'hFFFF, 16'h1000));
    vecs.push_back(mk(16'h0003, 16'h001C));
`else
    vecs.push_back(mk(16'hFFFF, 16'h0FFF));
    vecs.push_back(mk(16'h0003, 16'h001B));
`endif
    vecs.push_back(mk(16'h0100, 16'h0100));
    vecs.push_back(mk(16'h0001, 16'h0010));
    vecs.push_back(mk(16'h0200, 16'h016A));
    vecs.push_back(mk(16'h0900, 16'h0300));
    for (int i = 0; i < 6; i++) begin
      r16 = 16'($urandom_range(0, 65535));
      vecs.push_back(mk(r16, model_sqrt(r16)));
    end

    // Hold reset, then release on a falling edge so the next rising edge is LOAD.
    DATA_IN  = 16'h0400;
    exp_next = 16'h0200;
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // One vector per period. DATA_IN is scrambled mid-period to show it is ignored.
    for (int i = 0; i < vecs.size(); i++) begin
      DATA_IN  = vecs[i].din;
      exp_next = vecs[i].exp;
      wait_phase(3);
      DATA_IN = 16'($urandom_range(0, 65535));
      wait_phase(0);
    end

    // Input change at edge 5 applies only from the next LOAD.
    DATA_IN  = 16'h0400;
    exp_next = 16'h0200;
    wait_phase(5);
    DATA_IN  = 16'h6400;
    exp_next = 16'h0A00;
    wait_phase(0);
    wait_phase(0);

    // Reset at edge 8 of a period clears the output at once and aborts the computation.
    wait_phase(7);
    @(posedge CLK);
    #2 RST = 1'b0;
    DATA_IN  = 16'h0003;
    exp_next = model_sqrt(16'h0003);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    wait_phase(0);
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqrt_q88.md
SQRT_Q88 -- requirements
Module: sqrt_q88

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 CLK  input  1  clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset; RST=0 clears all state immediately.
REQ-004 DATA_IN  input  16  unsigned radicand, Q8.8 (8 integer bits, 8 fraction bits).
REQ-005 DATA_OUT  output  16  unsigned square root, Q8.8; bits [15:13] are always 0.

Function
REQ-006 The result SHALL be floor(sqrt(DATA_IN*256)), i.e. sqrt(DATA_IN/256) in Q8.8, truncated. This is the result when SQRT_ROUND_EN is undefined.
REQ-007 The internal radicand SHALL be 24 bits, {DATA_IN, 8'h00}. The root SHALL be 12 bits, zero-extended to 16 bits on DATA_OUT.
REQ-008 The algorithm SHALL be non-restoring or restoring digit-by-digit (radix-2) square root.
  - One root bit per clock, MSB first.
  - Partial remainder at least 14 bits wide; no overflow for any input.
REQ-009 The FSM SHALL have three states: LOAD, ITER, DONE.
  - LOAD: capture DATA_IN, clear root and remainder, set the bit counter to 11, go to ITER.
  - ITER: resolve one root bit per cycle. Go to DONE after the bit-0 cycle (12 ITER cycles).
  - DONE: DATA_OUT <= root, go to LOAD.
REQ-010 The first rising edge after RST deasserts SHALL be a LOAD edge.
REQ-011 DATA_OUT SHALL update on the 14th rising edge counted from and including the LOAD edge. The computation period is 14 cycles, free-running with no handshake.
REQ-012 DATA_OUT SHALL hold its value between DONE updates.
REQ-013 DATA_IN changes outside the LOAD edge SHALL be ignored until the next LOAD.
REQ-014 DATA_IN=0 SHALL yield DATA_OUT=0x0000.
REQ-015 DATA_IN=0xFFFF SHALL yield 0x0FFF when truncating.
REQ-016 The design SHALL have no combinational path from DATA_IN to DATA_OUT.

Reset
REQ-017 While RST=0: DATA_OUT=0x0000, state=LOAD, and root, remainder and counter are cleared.
REQ-018 Asserting RST mid-computation SHALL abort it; the partial result SHALL never appear on DATA_OUT.
REQ-019 After RST deasserts, the first valid DATA_OUT SHALL appear 14 edges later (per REQ-010 and REQ-011).

Configuration
REQ-020 Macro SQRT_ROUND_EN defined: DONE SHALL write root+1 when the final remainder > root, else root. This gives round-to-nearest, and 0xFFFF yields 0x1000.
REQ-021 Macro SQRT_ROUND_EN undefined: truncation per REQ-006. Latency and interface SHALL be identical in both builds.

Verification
REQ-022 Set DATA_IN=0x0400 (4.0), release RST -> DATA_OUT=0x0200 (2.0) at edge 14, stable thereafter.
REQ-023 DATA_IN=0x1E00 (30.0) -> DATA_OUT=0x057A (5.4766), in both builds.
REQ-024 Check the following inputs.
  - DATA_IN=0x6400 (100.0) -> 0x0A00 (10.0).
  - DATA_IN=0x0000 -> 0x0000.
  - DATA_IN=0xFFFF -> 0x0FFF, or 0x1000 with SQRT_ROUND_EN.
REQ-025 DATA_IN=0x0003 -> 0x001B truncated, or 0x001C with SQRT_ROUND_EN.
REQ-026 Mid-computation events:
  - Change DATA_IN 0x0400->0x6400 at edge 5 -> 0x0200 at edge 14, then 0x0A00 at edge 28.
  - Assert RST at edge 8 -> DATA_OUT=0x0000 immediately (asynchronously).
